// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer: IDLE -> DECODE -> EXEC [-> MEMWAIT] -> DECODE, sticky HALT.
// Defining CTRL_SEQ_PERF_CNT_EN adds the 16-bit retired-instruction counter output.
module ctrl_seq #(
  parameter int                   MCODEBITS = 9,
  parameter int                   OPW       = 3,
  parameter int                   ALUOPW    = 3,
  parameter int                   MEM_LAT   = 1,
  parameter logic [MCODEBITS-1:0] HALT_CODE = 9'b111011111
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [MCODEBITS-1:0] instr,
  input  logic                 instr_valid,
  input  logic                 zero,
  output logic                 RegDst,
  output logic                 Branch,
  output logic                 MemtoReg,
  output logic                 MemWrite,
  output logic                 ALUSrc,
  output logic                 RegWrite,
  output logic [1:0]           how_high,
  output logic [ALUOPW-1:0]    ALUOp,
  output logic                 pc_en,
  output logic                 stall,
  output logic                 done,
`ifdef CTRL_SEQ_PERF_CNT_EN
  output logic [15:0]          retired,
`endif
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MEMWAIT = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  localparam logic [OPW-1:0] OP_LOAD  = OPW'(5);
  localparam logic [OPW-1:0] OP_STORE = OPW'(6);
  localparam logic [OPW-1:0] OP_IMM   = OPW'(7);
  localparam logic [3:0]     LAT      = 4'(MEM_LAT);

  state_t               state_q, state_d;
  logic [MCODEBITS-1:0] ir_q, ir_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [OPW-1:0]       op;

  assign op        = ir_q[MCODEBITS-1 -: OPW];
  assign dbg_state = state_q;
  assign RegDst    = 1'b0;
  assign ALUSrc    = 1'b0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    cnt_d    = cnt_q;
    Branch   = 1'b0;
    MemtoReg = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    how_high = 2'b00;
    ALUOp    = '0;
    pc_en    = 1'b0;
    stall    = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_DECODE;
      S_DECODE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = (instr == HALT_CODE) ? S_HALT : S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_DECODE;
        case (op)
          OP_LOAD, OP_STORE: begin
            MemtoReg = (op == OP_LOAD);
            MemWrite = (op == OP_STORE);
            if (MEM_LAT == 0) begin
              RegWrite = (op == OP_LOAD);
              pc_en    = 1'b1;
            end else begin
              cnt_d   = LAT;
              state_d = S_MEMWAIT;
            end
          end
          OP_IMM: begin
            pc_en = 1'b1;
            if (ir_q[5]) begin
              ALUOp    = ALUOPW'(7);
              RegWrite = 1'b1;
            end else begin
              Branch   = zero;
              how_high = ir_q[4:3];
            end
          end
          default: begin
            ALUOp    = ALUOPW'(op);
            RegWrite = 1'b1;
            pc_en    = 1'b1;
          end
        endcase
      end
      S_MEMWAIT: begin
        stall    = 1'b1;
        MemtoReg = (op == OP_LOAD);
        MemWrite = (op == OP_STORE);
        cnt_d    = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          RegWrite = (op == OP_LOAD);
          pc_en    = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_HALT: done = 1'b1;
      default: state_d = S_IDLE;
    endcase
    // A reset cycle must never let a write or PC strobe escape.
    if (Reset) begin
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      pc_en    = 1'b0;
    end
  end

`ifdef CTRL_SEQ_PERF_CNT_EN
  logic [15:0] retired_q;
  always_ff @(posedge Clk) begin
    if (Reset) retired_q <= '0;
    else if (pc_en && state_q != S_HALT) retired_q <= retired_q + 16'd1;
  end
  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq (MEM_LAT=2): per-instruction expected cycle sequences in a queue,
// checked every cycle, plus directed literal checks from the test plan.
module tb_ctrl_seq;
  localparam int LAT = 2;
  localparam logic [8:0] HALT = 9'b111011111;
  localparam int P_IDLE = 0, P_WAIT = 1, P_PLAY = 2, P_HALT = 3;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, instr_valid = 1'b0, zero = 1'b0;
  logic [8:0] instr = '0;
  logic RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, pc_en, stall, done;
  logic [1:0] how_high;
  logic [2:0] ALUOp, dbg_state;
`ifdef CTRL_SEQ_PERF_CNT_EN
  logic [15:0] retired;
  int ret_m = 0;
`endif

  int vectors = 0, miscompares = 0, cyc = 0;
  int phase = P_IDLE;
  bit seen_rst = 1'b0, rnd_zero = 1'b0;
  // entry: {is_br, hh[1:0], aluop[2:0], mtr, mw, rw, pc, stall}
  logic [10:0] exp_q[$];
  logic [10:0] e;
  logic [13:0] exp_v, act_v;

  ctrl_seq #(.MEM_LAT(LAT)) dut (
    .Clk(clk), .Reset(rst), .start(start), .instr(instr), .instr_valid(instr_valid),
    .zero(zero), .RegDst(RegDst), .Branch(Branch), .MemtoReg(MemtoReg),
    .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .how_high(how_high),
    .ALUOp(ALUOp), .pc_en(pc_en), .stall(stall), .done(done),
`ifdef CTRL_SEQ_PERF_CNT_EN
    .retired(retired),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  assign act_v = {RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite,
                  how_high, ALUOp, pc_en, stall, done};

  function automatic logic [10:0] mk(logic br, logic [1:0] hh, logic [2:0] alu,
                                     logic mtr, logic mw, logic rw, logic pc, logic st);
    return {br, hh, alu, mtr, mw, rw, pc, st};
  endfunction

  // Expected per-cycle behaviour of one non-halt instruction, from EXEC onwards.
  task automatic push_seq(input logic [8:0] ins);
    logic [2:0] op;
    logic ld;
    op = ins[8:6];
    if (op <= 3'd4) exp_q.push_back(mk(1'b0, 2'b00, op, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    else if (op == 3'd5 || op == 3'd6) begin
      ld = (op == 3'd5);
      if (LAT == 0) exp_q.push_back(mk(1'b0, 2'b00, 3'd0, ld, !ld, ld, 1'b1, 1'b0));
      else begin
        exp_q.push_back(mk(1'b0, 2'b00, 3'd0, ld, !ld, 1'b0, 1'b0, 1'b0));
        for (int k = 1; k <= LAT; k++)
          exp_q.push_back(mk(1'b0, 2'b00, 3'd0, ld, !ld, ld && (k == LAT), k == LAT, 1'b1));
      end
    end else if (ins[5]) exp_q.push_back(mk(1'b0, 2'b00, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    else exp_q.push_back(mk(1'b1, ins[4:3], 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) seen_rst <= 1'b1;
  end

  // Model step + compare, once per cycle while inputs are stable.
  always @(negedge clk) begin
    if (seen_rst) begin
      e = '0;
      if (phase == P_PLAY) e = exp_q[0];
      if (rst) e[3:1] = 3'b000;
      exp_v = {1'b0, e[10] & zero, e[4], e[3], 1'b0, e[2], e[9:8], e[7:5], e[1], e[0],
               phase == P_HALT};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL outputs cyc=%0d got=%b want=%b", cyc, act_v, exp_v);
      end
`ifdef CTRL_SEQ_PERF_CNT_EN
      vectors++;
      if (retired !== 16'(ret_m)) begin
        miscompares++;
        $display("FAIL retired cyc=%0d got=%0d want=%0d", cyc, retired, ret_m);
      end
      ret_m = rst ? 0 : ((ret_m + int'(e[1])) & 16'hFFFF);
`endif
      if (rst) begin
        phase = P_IDLE;
        exp_q.delete();
      end else begin
        case (phase)
          P_IDLE: if (start) phase = P_WAIT;
          P_WAIT: if (instr_valid) begin
            if (instr == HALT) phase = P_HALT;
            else begin
              push_seq(instr);
              phase = P_PLAY;
            end
          end
          P_PLAY: begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) phase = P_WAIT;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_zero) zero = 1'($urandom_range(0, 1));
  endtask

  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%b want=%b", name, act, exp);
    end
  endtask

  task automatic issue(input logic [8:0] ins);
    int guard;
    guard = 0;
    while (phase != P_WAIT && guard < 50) begin
      start = (phase == P_IDLE);
      tick();
      guard++;
    end
    start = 1'b0;
    vectors++;
    if (phase != P_WAIT) begin
      miscompares++;
      $display("FAIL issue_timeout got=phase%0d want=phase%0d", phase, P_WAIT);
    end else begin
      instr = ins;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      instr = 9'($urandom);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  function automatic logic [8:0] rnd_instr();
    logic [8:0] r;
    r = 9'($urandom);
    if (r == HALT) r[0] = 1'b0;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lit("idle_zero", 16'(act_v), 16'd0);
      tick();
    end

    issue(9'b000_000_001);
    @(negedge clk);
    lit("alu_exec", {13'd0, RegWrite, pc_en, ALUOp == 3'b000}, 16'b111);
    @(negedge clk);
    lit("alu_back_decode", 16'(act_v), 16'd0);

    issue(9'b101_000_000);
    @(negedge clk); lit("load_c1", {12'd0, MemtoReg, stall, RegWrite, pc_en}, 16'b1000);
    tick(); @(negedge clk); lit("load_c2", {12'd0, MemtoReg, stall, RegWrite, pc_en}, 16'b1100);
    tick(); @(negedge clk); lit("load_c3", {12'd0, MemtoReg, stall, RegWrite, pc_en}, 16'b1111);
    tick(); @(negedge clk); lit("load_after", 16'(act_v), 16'd0);

    zero = 1'b1;
    issue(9'b111_0_10_000);
    @(negedge clk);
    lit("branch_taken", {11'd0, Branch, how_high, pc_en, RegWrite}, 16'b11010);
    zero = 1'b0;
    issue(9'b111_0_10_000);
    @(negedge clk);
    lit("branch_not_taken", {11'd0, Branch, how_high, pc_en, RegWrite}, 16'b01010);

    issue(9'b110_000_000);
    @(negedge clk); lit("store_exec", {14'd0, MemWrite, stall}, 16'b10);
    tick(); @(negedge clk); lit("store_wait1", {14'd0, MemWrite, stall}, 16'b11);
    tick(); rst = 1'b1;
    @(negedge clk); lit("store_rst_cycle", {13'd0, MemWrite, pc_en, RegWrite}, 16'd0);
    tick(); rst = 1'b0;
    @(negedge clk); lit("store_after_rst", {13'd0, MemWrite, pc_en, stall}, 16'd0);
    repeat (3) tick();
    @(negedge clk); lit("idle_after_rst", 16'(act_v), 16'd0);

    rnd_zero = 1'b1;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 39) == 0) do_reset(1);
      repeat ($urandom_range(0, 2)) tick();
      issue(rnd_instr());
    end
    rnd_zero = 1'b0;

    do_reset(2);
    issue(9'b011_000_111);
    issue(9'b101_001_000);
    issue(9'b111_1_00_010);
    issue(HALT);
    @(negedge clk); lit("halt_done", {15'd0, done}, 16'd1);
`ifdef CTRL_SEQ_PERF_CNT_EN
    lit("retired_three", retired, 16'd3);
`endif
    for (int i = 0; i < 4; i++) begin
      start = ~start;
      instr_valid = 1'b1;
      tick();
      @(negedge clk); lit("halt_sticky", {15'd0, done}, 16'd1);
    end
    start = 1'b0;
    instr_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
